// File: rtl/pcs_pkg.sv
// pcs_pkg: shared constants, block layout and the payload scrambler helper
// for the TX PCS gearbox path (tx_gearbox and scrambler_64b66b).
package pcs_pkg;

   localparam logic [1:0] SYNC_DATA = 2'b01;
   localparam logic [1:0] SYNC_CTRL = 2'b10;

   localparam int PCS_DATA_WIDTH    = 66;
   localparam int PCS_PAYLOAD_WIDTH = 64;
   localparam int GBX_OUT_WIDTH     = 32;
   localparam int GBX_BUF_WIDTH     = 128;
   localparam int GBX_CNT_WIDTH     = 8;

   // Highest fill level that still leaves room for a whole block.
   localparam int GBX_READY_LIMIT = GBX_BUF_WIDTH - PCS_DATA_WIDTH;

   localparam int             SCR_WIDTH = 58;
   localparam int             SCR_TAP_A = 38;
   localparam int             SCR_TAP_B = 57;
   localparam logic [57:0]    SCR_SEED  = 58'h3FF_FFFF_FFFF_FFFF;

   typedef struct packed {
      logic [1:0]  sync;
      logic [63:0] payload;
   } pcs_block_t;

   typedef struct packed {
      logic [63:0] data;
      logic [57:0] state;
   } scr_result_t;

   // Scramble one payload in serial order (bit 63 first). Each scrambled bit
   // is fed back into the state, so after 64 bits the state is simply the
   // last 58 scrambled bits.
   function automatic scr_result_t scramble_payload(input logic [63:0] d,
                                                    input logic [57:0] s_in);
      scr_result_t res;
      logic [57:0] s;
      logic        b;
      s = s_in;
      res = '0;
      for (int i = PCS_PAYLOAD_WIDTH - 1; i >= 0; i--) begin
         b = d[i] ^ s[SCR_TAP_A] ^ s[SCR_TAP_B];
         res.data[i] = b;
         s = {s[SCR_WIDTH-2:0], b};
      end
      res.state = s;
      return res;
   endfunction

endpackage

// File: rtl/scrambler_64b66b.sv
// scrambler_64b66b: self-synchronous x^58 + x^39 + 1 payload scrambler.
// Output is combinational on data_in; the state only advances on enable.
// Only instantiated by tx_gearbox when TX_GEARBOX_SCRAMBLE_EN is defined.
module scrambler_64b66b
   import pcs_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [63:0] data_in,
   output logic [63:0] data_out
);

   logic [57:0] state;
   scr_result_t result;

   // Scramble the presented payload against the current state.
   always_comb begin
      result = scramble_payload(data_in, state);
   end

   assign data_out = result.data;

   // State advances only when the payload is actually consumed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= SCR_SEED;
      end else if (enable) begin
         state <= result.state;
      end
   end

endmodule

// File: rtl/tx_gearbox.sv
// tx_gearbox: repacks 66-bit encoded blocks into a gap-free MSB-first stream
// of 32-bit words. A 128-bit left-aligned bit buffer holds unsent bits; the
// encoder is throttled whenever a full block would not fit.
// Optional feature macro: TX_GEARBOX_SCRAMBLE_EN scrambles each block payload
// on the push path (sync header bypasses the scrambler).
module tx_gearbox
   import pcs_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [65:0] encoded_data_in,
   input  logic        encoded_valid_in,
   output logic        encoded_ready_out,
   output logic [31:0] pcs_data_out,
   output logic        pcs_valid_out,
   input  logic        pcs_ready_in
);

   localparam logic [GBX_CNT_WIDTH-1:0] OUT_BITS    = GBX_CNT_WIDTH'(GBX_OUT_WIDTH);
   localparam logic [GBX_CNT_WIDTH-1:0] BLOCK_BITS  = GBX_CNT_WIDTH'(PCS_DATA_WIDTH);
   localparam logic [GBX_CNT_WIDTH-1:0] READY_LIMIT = GBX_CNT_WIDTH'(GBX_READY_LIMIT);
   localparam int                       PAD_BITS    = GBX_BUF_WIDTH - PCS_DATA_WIDTH;

   logic [GBX_BUF_WIDTH-1:0] bit_buf;
   logic [GBX_BUF_WIDTH-1:0] buf_next;
   logic [GBX_BUF_WIDTH-1:0] shifted;
   logic [GBX_BUF_WIDTH-1:0] aligned;
   logic [GBX_CNT_WIDTH-1:0] cnt;
   logic [GBX_CNT_WIDTH-1:0] cnt_next;
   logic [GBX_CNT_WIDTH-1:0] base_cnt;
   logic [63:0]              payload;
   logic                     push;
   logic                     pop;

`ifdef TX_GEARBOX_SCRAMBLE_EN
   scrambler_64b66b u_scrambler (
      .clk      (clk),
      .rst      (rst),
      .enable   (push),
      .data_in  (encoded_data_in[63:0]),
      .data_out (payload)
   );
`else
   assign payload = encoded_data_in[63:0];
`endif

   // Handshake outputs depend on the registered fill level only.
   assign encoded_ready_out = (cnt <= READY_LIMIT);
   assign pcs_valid_out     = (cnt >= OUT_BITS);
   assign pcs_data_out      = bit_buf[GBX_BUF_WIDTH-1 -: GBX_OUT_WIDTH];

   assign push = encoded_valid_in & encoded_ready_out;
   assign pop  = pcs_valid_out & pcs_ready_in;

   // Next buffer: drop the outgoing word first, then append the new block
   // directly behind the remaining valid bits.
   always_comb begin
      aligned  = {encoded_data_in[65:64], payload, {PAD_BITS{1'b0}}};
      shifted  = bit_buf;
      base_cnt = cnt;
      if (pop) begin
         shifted  = {bit_buf[GBX_BUF_WIDTH-GBX_OUT_WIDTH-1:0], {GBX_OUT_WIDTH{1'b0}}};
         base_cnt = cnt - OUT_BITS;
      end
      buf_next = shifted;
      cnt_next = base_cnt;
      if (push) begin
         buf_next = shifted | (aligned >> base_cnt);
         cnt_next = base_cnt + BLOCK_BITS;
      end
   end

   // Buffer and fill-level registers; reset discards any partial block.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bit_buf <= '0;
         cnt     <= '0;
      end else begin
         bit_buf <= buf_next;
         cnt     <= cnt_next;
      end
   end

endmodule

// File: tb/tb_tx_gearbox.sv
// tb_tx_gearbox: randomized self-checking bench for tx_gearbox. The reference
// model is a plain bit queue in serial order (plus a serial scrambler history
// when TX_GEARBOX_SCRAMBLE_EN is defined).
module tb_tx_gearbox;

   logic        clk = 1'b0;
   logic        rst;
   logic [65:0] encoded_data_in;
   logic        encoded_valid_in;
   logic        encoded_ready_out;
   logic [31:0] pcs_data_out;
   logic        pcs_valid_out;
   logic        pcs_ready_in;

   int total = 0;
   int bad   = 0;

   bit model_q[$];
   bit scr_hist[$];
   int words_seen;
   int ready_low_seen;

   tx_gearbox dut (
      .clk               (clk),
      .rst               (rst),
      .encoded_data_in   (encoded_data_in),
      .encoded_valid_in  (encoded_valid_in),
      .encoded_ready_out (encoded_ready_out),
      .pcs_data_out      (pcs_data_out),
      .pcs_valid_out     (pcs_valid_out),
      .pcs_ready_in      (pcs_ready_in)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] modelWord();
      logic [31:0] w;
      w = '0;
      for (int i = 0; i < 32; i++) begin
         if (i < model_q.size()) w[31-i] = model_q[i];
      end
      return w;
   endfunction

   task automatic modelReset();
      model_q.delete();
      scr_hist.delete();
      repeat (58) scr_hist.push_back(1'b1);
   endtask

   // Append a block to the serial stream, scrambling the payload bit by bit.
   task automatic modelPush(input logic [65:0] blk);
      bit o;
      model_q.push_back(blk[65]);
      model_q.push_back(blk[64]);
      for (int i = 63; i >= 0; i--) begin
`ifdef TX_GEARBOX_SCRAMBLE_EN
         // scr_hist[57] is the newest bit: index 19 is 39 bits back, 0 is 58 back.
         o = blk[i] ^ scr_hist[19] ^ scr_hist[0];
         scr_hist.push_back(o);
         void'(scr_hist.pop_front());
`else
         o = blk[i];
`endif
         model_q.push_back(o);
      end
   endtask

   task automatic modelPop();
      repeat (32) void'(model_q.pop_front());
   endtask

   function automatic logic [65:0] randBlock();
      logic [1:0] sync;
      sync = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      return {sync, $urandom(), $urandom()};
   endfunction

   // One clock cycle: entered and left at posedge+1. Checks outputs at the
   // negedge against the model, then applies the expected transfers.
   task automatic applyStimulus(input logic v, input logic [65:0] d, input logic r,
                                output logic pushed);
      logic exp_ready;
      logic exp_valid;
      logic popped;
      encoded_valid_in = v;
      encoded_data_in  = d;
      pcs_ready_in     = r;
      @(negedge clk);
      exp_ready = (model_q.size() <= 62);
      exp_valid = (model_q.size() >= 32);
      checkOutput("ready", 32'(encoded_ready_out), 32'(exp_ready));
      checkOutput("valid", 32'(pcs_valid_out), 32'(exp_valid));
      if (exp_valid) checkOutput("data", pcs_data_out, modelWord());
      if (!exp_ready) ready_low_seen++;
      pushed = v & exp_ready;
      popped = exp_valid & r;
      @(posedge clk);
      #1;
      if (popped) begin
         modelPop();
         words_seen++;
      end
      if (pushed) modelPush(d);
   endtask

   // Asynchronous reset between clock edges; outputs checked before any edge.
   task automatic doReset();
      #3;
      rst = 1'b0;
      #1;
      checkOutput("rst_valid", 32'(pcs_valid_out), 32'd0);
      checkOutput("rst_data", pcs_data_out, 32'd0);
      checkOutput("rst_ready", 32'(encoded_ready_out), 32'd1);
      encoded_valid_in = 1'b0;
      pcs_ready_in     = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      modelReset();
   endtask

   initial begin
      logic        pushed;
      logic [65:0] blk;
      logic [31:0] held;
      int          pushes;
      int          cyc;
      int          low33;
      int          words0;

      rst              = 1'b0;
      encoded_valid_in = 1'b0;
      encoded_data_in  = '0;
      pcs_ready_in     = 1'b0;
      words_seen       = 0;
      ready_low_seen   = 0;
      modelReset();
      @(posedge clk);
      #1;

      // Reset then idle.
      doReset();
      repeat (3) applyStimulus(1'b0, '0, 1'b1, pushed);

      // Single known block.
`ifdef TX_GEARBOX_SCRAMBLE_EN
      applyStimulus(1'b1, {2'b10, 64'h0}, 1'b1, pushed);
      #3;
      checkOutput("scr_word0", pcs_data_out, 32'h80000000);
      applyStimulus(1'b0, '0, 1'b1, pushed);
      applyStimulus(1'b0, '0, 1'b1, pushed);
`else
      applyStimulus(1'b1, {2'b01, 64'h0123456789ABCDEF}, 1'b1, pushed);
      #3;
      checkOutput("t2_word0", pcs_data_out, 32'h4048D159);
      applyStimulus(1'b0, '0, 1'b1, pushed);
      #3;
      checkOutput("t2_word1", pcs_data_out, 32'hE26AF37B);
      applyStimulus(1'b0, '0, 1'b1, pushed);
`endif
      #3;
      checkOutput("t2_tail_valid", 32'(pcs_valid_out), 32'd0);
      checkOutput("t2_tail_ready", 32'(encoded_ready_out), 32'd1);
      applyStimulus(1'b0, '0, 1'b1, pushed);

      // Sixteen back-to-back blocks with the output always ready.
      doReset();
      pushes         = 0;
      words0         = words_seen;
      ready_low_seen = 0;
      low33          = 0;
      blk            = randBlock();
      for (int c = 1; c <= 40; c++) begin
         applyStimulus(pushes < 16, blk, 1'b1, pushed);
         if (pushed) begin
            pushes++;
            blk = randBlock();
         end
         if (c == 33) low33 = ready_low_seen;
      end
      checkOutput("t3_pushes", 32'(pushes), 32'd16);
      checkOutput("t3_words", 32'(words_seen - words0), 32'd33);
      checkOutput("t3_ready_low", 32'(low33), 32'd17);

      // Backpressure: output stalled while the encoder keeps offering.
      doReset();
      pushes = 0;
      blk    = randBlock();
      applyStimulus(1'b1, blk, 1'b0, pushed);
      if (pushed) begin
         pushes++;
         blk = randBlock();
      end
      #3;
      held = pcs_data_out;
      for (int c = 0; c < 12; c++) begin
         applyStimulus(1'b1, blk, 1'b0, pushed);
         if (pushed) begin
            pushes++;
            blk = randBlock();
         end
         #3;
         checkOutput("t4_stable", pcs_data_out, held);
      end
      checkOutput("t4_pushes", 32'(pushes), 32'd1);
      for (int c = 0; c < 60; c++) begin
         applyStimulus(1'b1, blk, 1'($urandom_range(0, 1)), pushed);
         if (pushed) blk = randBlock();
      end

      // Random valid/ready over 10k blocks, with one mid-stream reset.
      pushes = 0;
      cyc    = 0;
      blk    = randBlock();
      while (pushes < 10000 && cyc < 60000) begin
         applyStimulus($urandom_range(0, 3) != 0, blk, $urandom_range(0, 3) != 0, pushed);
         cyc++;
         if (pushed) begin
            pushes++;
            blk = randBlock();
            if (pushes == 300) doReset();
         end
      end
      checkOutput("t5_blocks", 32'(pushes), 32'd10000);
      cyc = 0;
      while (model_q.size() >= 32 && cyc < 100) begin
         applyStimulus(1'b0, '0, 1'b1, pushed);
         cyc++;
      end
      #3;
      checkOutput("t5_drained", 32'(pcs_valid_out), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
